// File: rtl/im_mem_pkg.sv
// Shared encodings and helpers for the memory-access stage.
package im_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Little-endian lane mask; size 11 falls through to a full word.
    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] a);
        logic [3:0] be;
        be = 4'b1111;
        unique case (1'b1)
            size == SZ_BYTE: be = 4'b0001 << a;
            size == SZ_HALF: be = 4'b0011 << {a[1], 1'b0};
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/im_load_align.sv
// Picks the addressed lane out of a read word and sign/zero-extends it.
module im_load_align
    import im_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh = i_rdata >> {i_addr, 3'b000};

    always_comb begin
        o_data = w_sh;
        unique case (1'b1)
            i_size == SZ_BYTE:
                o_data = {{24{w_sh[7] & ~i_unsigned}}, w_sh[7:0]};
            i_size == SZ_HALF:
                o_data = {{16{w_sh[15] & ~i_unsigned}}, w_sh[15:0]};
            default:
                o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/im_mem_stage.sv
// Memory-access stage: byte/half/word loads and stores over a req/ack
// data-memory handshake, retiring into the IM/IW pipeline register.
module im_mem_stage
    import im_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ix_valid,
    input  logic [31:0] ix_pc,
    input  logic [31:0] ix_O,
    input  logic [31:0] ix_B,
    input  logic        ix_mem_read,
    input  logic        ix_mem_write,
    input  logic [1:0]  ix_size,
    input  logic        ix_unsigned,
    input  logic        ix_res_data_sel,
    input  logic        ix_write_to_reg,
    input  logic        ix_dest_reg_sel,
    input  logic [4:0]  ix_rt,
    input  logic [4:0]  ix_rd,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        im_valid,
    output logic [31:0] im_pc,
    output logic [31:0] im_O,
    output logic [31:0] im_D,
    output logic        im_res_data_sel,
    output logic        im_write_to_reg,
    output logic        im_dest_reg_sel,
    output logic [4:0]  im_rt,
    output logic [4:0]  im_rd,
    output logic        misaligned_exc,
    output logic        timeout_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;

    logic        w_idle;
    logic        w_mem;
    logic        w_ld;
    logic        w_mis;
    logic        w_issue;
    logic        w_ack;
    logic        w_tmo;
    logic        w_ret;
    logic        w_wtr;
    logic [31:0] w_load;
    logic [31:0] w_D;
    logic [31:0] w_wdata;

    // Upstream holds ix_* while stalled, so the live inputs still
    // describe the outstanding access when the ack arrives.
    im_load_align u_align (
        .i_rdata    (dm_rdata),
        .i_addr     (ix_O[1:0]),
        .i_size     (ix_size),
        .i_unsigned (ix_unsigned),
        .o_data     (w_load)
    );

    always_comb begin
        w_mis   = 1'b0;
        w_wdata = ix_B;
        unique case (1'b1)
            ix_size == SZ_BYTE: begin
                w_mis   = 1'b0;
                w_wdata = {4{ix_B[7:0]}};
            end
            ix_size == SZ_HALF: begin
                w_mis   = ix_O[0];
                w_wdata = {2{ix_B[15:0]}};
            end
            default: begin
                w_mis   = |ix_O[1:0];
                w_wdata = ix_B;
            end
        endcase
    end

    assign w_idle  = (r_state == ST_IDLE);
    assign w_mem   = ix_mem_read | ix_mem_write;
    assign w_ld    = ix_mem_read & ~ix_mem_write;
    assign w_issue = w_idle & ix_valid & w_mem & ~w_mis;
    assign w_ack   = ~w_idle & dm_ack;
    assign w_tmo   = ~w_idle & ~dm_ack & (r_cnt == LAST);
    assign w_ret   = (w_idle & ix_valid & ~w_issue) | w_ack | w_tmo;
    assign w_wtr   = ix_write_to_reg & (w_idle ? ~w_mem : w_ack);
    assign w_D     = (w_ack & w_ld) ? w_load : 32'd0;
    assign stall   = ~w_idle | w_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_valid        <= 1'b0;
            misaligned_exc  <= 1'b0;
            timeout_err     <= 1'b0;
            im_pc           <= '0;
            im_O            <= '0;
            im_D            <= '0;
            im_res_data_sel <= 1'b0;
            im_write_to_reg <= 1'b0;
            im_dest_reg_sel <= 1'b0;
            im_rt           <= '0;
            im_rd           <= '0;
        end else begin
            im_valid       <= w_ret;
            misaligned_exc <= w_idle & ix_valid & w_mem & w_mis;
            if (w_tmo) begin
                timeout_err <= 1'b1;
            end
            if (w_ret) begin
                im_pc           <= ix_pc;
                im_O            <= ix_O;
                im_D            <= w_D;
                im_res_data_sel <= ix_res_data_sel;
                im_write_to_reg <= w_wtr;
                im_dest_reg_sel <= ix_dest_reg_sel;
                im_rt           <= ix_rt;
                im_rd           <= ix_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= '0;
            dm_wdata <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state  <= ST_ACCESS;
                        r_cnt    <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= ix_mem_write;
                        dm_addr  <= {ix_O[31:2], 2'b00};
                        dm_be    <= byte_en(ix_size, ix_O[1:0]);
                        dm_wdata <= w_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (w_ack | w_tmo) begin
                        r_state <= ST_IDLE;
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_mem_stage.sv
// Randomized bench for im_mem_stage with a behavioural retire model.
module tb_im_mem_stage;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ix_valid;
    logic [31:0] ix_pc;
    logic [31:0] ix_O;
    logic [31:0] ix_B;
    logic        ix_mem_read;
    logic        ix_mem_write;
    logic [1:0]  ix_size;
    logic        ix_unsigned;
    logic        ix_res_data_sel;
    logic        ix_write_to_reg;
    logic        ix_dest_reg_sel;
    logic [4:0]  ix_rt;
    logic [4:0]  ix_rd;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
    logic        im_valid;
    logic [31:0] im_pc;
    logic [31:0] im_O;
    logic [31:0] im_D;
    logic        im_res_data_sel;
    logic        im_write_to_reg;
    logic        im_dest_reg_sel;
    logic [4:0]  im_rt;
    logic [4:0]  im_rd;
    logic        misaligned_exc;
    logic        timeout_err;

    im_mem_stage #(.MAX_WAIT(MW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ix_valid        (ix_valid),
        .ix_pc           (ix_pc),
        .ix_O            (ix_O),
        .ix_B            (ix_B),
        .ix_mem_read     (ix_mem_read),
        .ix_mem_write    (ix_mem_write),
        .ix_size         (ix_size),
        .ix_unsigned     (ix_unsigned),
        .ix_res_data_sel (ix_res_data_sel),
        .ix_write_to_reg (ix_write_to_reg),
        .ix_dest_reg_sel (ix_dest_reg_sel),
        .ix_rt           (ix_rt),
        .ix_rd           (ix_rd),
        .dm_req          (dm_req),
        .dm_we           (dm_we),
        .dm_addr         (dm_addr),
        .dm_be           (dm_be),
        .dm_wdata        (dm_wdata),
        .dm_ack          (dm_ack),
        .dm_rdata        (dm_rdata),
        .stall           (stall),
        .im_valid        (im_valid),
        .im_pc           (im_pc),
        .im_O            (im_O),
        .im_D            (im_D),
        .im_res_data_sel (im_res_data_sel),
        .im_write_to_reg (im_write_to_reg),
        .im_dest_reg_sel (im_dest_reg_sel),
        .im_rt           (im_rt),
        .im_rd           (im_rd),
        .misaligned_exc  (misaligned_exc),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] o;
        logic [31:0] d;
        logic        wtr;
        logic        rsel;
        logic        dsel;
        logic        mis;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    exp_t        q[$];
    exp_t        m_last;
    exp_t        c_e;
    logic        m_tmo;
    bit          cmp_en;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_be;
    logic        l_we;
    int          l_stalls;
    int          l_reqs;
    int          l_lat;
    int          rk;
    logic        rrd;
    logic        rwr;
    logic [31:0] ro;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [31:0] r,
                                             input logic [1:0] a,
                                             input logic [1:0] sz,
                                             input logic u);
        logic [31:0] v;
        v = r >> (8 * int'(a));
        if (sz == 2'b00) begin
            v = v % 256;
            if (!u && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            v = v % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n && cmp_en) begin
            chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
            if (im_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious im_valid: got 1 want 0 at %0t", $time);
                end else begin
                    c_e = q.pop_front();
                    chk("im_pc", im_pc, c_e.pc);
                    chk("im_O", im_O, c_e.o);
                    chk("im_D", im_D, c_e.d);
                    chk("im_wtr", 32'(im_write_to_reg), 32'(c_e.wtr));
                    chk("im_rsel", 32'(im_res_data_sel), 32'(c_e.rsel));
                    chk("im_dsel", 32'(im_dest_reg_sel), 32'(c_e.dsel));
                    chk("im_rt", 32'(im_rt), 32'(c_e.rt));
                    chk("im_rd", 32'(im_rd), 32'(c_e.rd));
                    chk("misaligned_exc", 32'(misaligned_exc), 32'(c_e.mis));
                    m_last = c_e;
                end
            end else begin
                chk("exc idle", 32'(misaligned_exc), 32'd0);
                chk("hold im_O", im_O, m_last.o);
                chk("hold im_D", im_D, m_last.d);
                chk("hold im_pc", im_pc, m_last.pc);
                chk("hold im_wtr", 32'(im_write_to_reg), 32'(m_last.wtr));
            end
        end
    end

    // Presents one instruction at a negedge, plays memory, returns at
    // the negedge after it retires with ix_valid dropped.
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] o,
                         input logic [31:0] b, input int ackn,
                         input logic [31:0] rdat, input logic wtr);
        exp_t        e;
        logic        mem;
        logic        mis;
        logic        ld;
        logic        to;
        int          n_exp;
        int          nreq;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        bit          done;
        ix_valid        = 1'b1;
        ix_pc           = $urandom;
        ix_O            = o;
        ix_B            = b;
        ix_mem_read     = rd;
        ix_mem_write    = wr;
        ix_size         = sz;
        ix_unsigned     = uns;
        ix_res_data_sel = 1'($urandom);
        ix_write_to_reg = wtr;
        ix_dest_reg_sel = 1'($urandom);
        ix_rt           = 5'($urandom);
        ix_rd           = 5'($urandom);
        mem = rd | wr;
        ld  = rd & ~wr;
        mis = mem && ((sz == 2'b01 && o[0]) || (sz[1] && o[1:0] != 2'b00));
        to  = mem && !mis && !(ackn >= 1 && ackn <= MW);
        n_exp = (!mem || mis) ? 0 : (to ? MW : ackn);
        e.pc   = ix_pc;
        e.o    = o;
        e.rsel = ix_res_data_sel;
        e.dsel = ix_dest_reg_sel;
        e.rt   = ix_rt;
        e.rd   = ix_rd;
        e.mis  = mis;
        e.wtr  = wtr && !mis && !to;
        e.d    = (ld && !mis && !to) ? ext_load(rdat, o[1:0], sz, uns) : 32'd0;
        q.push_back(e);
        if (sz == 2'b00) begin
            e_be    = 4'b0001 << o[1:0];
            e_wdata = {24'd0, b[7:0]} * 32'h01010101;
        end else if (sz == 2'b01) begin
            e_be    = 4'b0011 << o[1:0];
            e_wdata = {16'd0, b[15:0]} * 32'h00010001;
        end else begin
            e_be    = 4'b1111;
            e_wdata = b;
        end
        nreq     = 0;
        l_stalls = 0;
        l_lat    = 0;
        done     = 1'b0;
        for (int k = 0; k < MW + 4 && !done; k++) begin
            #1;
            if (stall) l_stalls++;
            if (dm_req) begin
                nreq++;
                chk("dm_addr", dm_addr, {o[31:2], 2'b00});
                chk("dm_be", 32'(dm_be), 32'(e_be));
                chk("dm_we", 32'(dm_we), 32'(wr));
                chk("dm_wdata", dm_wdata, e_wdata);
                l_addr  = dm_addr;
                l_be    = dm_be;
                l_we    = dm_we;
                l_wdata = dm_wdata;
                dm_ack   = (nreq == ackn);
                dm_rdata = dm_ack ? rdat : $urandom;
                if (to && nreq == MW) m_tmo = 1'b1;
            end
            @(posedge clk);
            #1;
            l_lat++;
            done = im_valid;
            @(negedge clk);
            dm_ack = 1'b0;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL retire: got no im_valid want one within %0d cycles", MW + 4);
        end
        l_reqs = nreq;
        chk("stall cycles", l_stalls, (mem && !mis) ? n_exp + 1 : 0);
        chk("req cycles", nreq, n_exp);
        chk("latency", l_lat, n_exp + 1);
        ix_valid = 1'b0;
    endtask

    initial begin
        ix_valid = 0; ix_pc = 0; ix_O = 0; ix_B = 0;
        ix_mem_read = 0; ix_mem_write = 0; ix_size = 0; ix_unsigned = 0;
        ix_res_data_sel = 0; ix_write_to_reg = 0; ix_dest_reg_sel = 0;
        ix_rt = 0; ix_rd = 0; dm_ack = 0; dm_rdata = 0;
        m_tmo = 0; m_last = '{default: '0}; cmp_en = 0;
        repeat (2) @(negedge clk);
        chk("rst dm_req", 32'(dm_req), 0);
        chk("rst dm_be", 32'(dm_be), 0);
        chk("rst im_valid", 32'(im_valid), 0);
        chk("rst im_O", im_O, 0);
        chk("rst timeout_err", 32'(timeout_err), 0);
        chk("rst stall", 32'(stall), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        do_op(0, 0, 2'b10, 0, 32'h100, 32'h0, 0, 32'h0, 1);
        chk("alu im_O", im_O, 32'h100);
        chk("alu im_D", im_D, 0);
        chk("alu stall", l_stalls, 0);

        do_op(1, 0, 2'b10, 0, 32'h204, 32'h0, 3, 32'hDEADBEEF, 1);
        chk("lw addr", l_addr, 32'h204);
        chk("lw be", 32'(l_be), 32'hF);
        chk("lw stall", l_stalls, 4);
        chk("lw im_D", im_D, 32'hDEADBEEF);

        do_op(1, 0, 2'b00, 0, 32'h203, 32'h0, 1, 32'h80112233, 1);
        chk("lb be", 32'(l_be), 32'h8);
        chk("lb im_D", im_D, 32'hFFFFFF80);
        do_op(1, 0, 2'b00, 1, 32'h203, 32'h0, 2, 32'h80112233, 1);
        chk("lbu im_D", im_D, 32'h00000080);

        do_op(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 1, 32'h0, 1);
        chk("sh we", 32'(l_we), 1);
        chk("sh be", 32'(l_be), 32'hC);
        chk("sh wdata", l_wdata, 32'hABCDABCD);

        do_op(1, 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h0, 1);
        chk("mis reqs", l_reqs, 0);
        chk("mis exc", 32'(misaligned_exc), 1);
        chk("mis wtr", 32'(im_write_to_reg), 0);

        do_op(1, 0, 2'b10, 0, 32'h40, 32'h0, MW, 32'h12345678, 1);
        chk("ack@limit tmo", 32'(timeout_err), 0);
        chk("ack@limit D", im_D, 32'h12345678);

        dm_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle ack req", 32'(dm_req), 0);
        end
        dm_ack = 1'b0;

        for (int i = 0; i < 60; i++) begin
            rk  = $urandom_range(0, 3);
            rrd = (rk == 1) || (rk == 3);
            rwr = (rk >= 2);
            ro  = $urandom;
            if ($urandom_range(0, 3) != 0) ro[1:0] = 2'b00;
            do_op(rrd, rwr, 2'($urandom), 1'($urandom), ro, $urandom,
                  $urandom_range(1, MW), $urandom, 1'($urandom));
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        do_op(1, 0, 2'b10, 0, 32'h300, 32'h0, 0, 32'h0, 1);
        chk("tmo reqs", l_reqs, MW);
        chk("tmo err", 32'(timeout_err), 1);
        chk("tmo wtr", 32'(im_write_to_reg), 0);
        do_op(0, 0, 2'b00, 0, 32'h55, 32'h0, 0, 32'h0, 1);
        do_op(0, 1, 2'b10, 0, 32'h58, 32'h9, 2, 32'h0, 1);

        ix_valid = 1'b1; ix_mem_read = 1'b1; ix_mem_write = 1'b0;
        ix_size = 2'b10; ix_O = 32'h400;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre-rst req", 32'(dm_req), 1);
        cmp_en = 1'b0;
        #2;
        rst_n    = 1'b0;
        ix_valid = 1'b0;
        #1;
        chk("arst dm_req", 32'(dm_req), 0);
        chk("arst dm_addr", dm_addr, 0);
        chk("arst dm_be", 32'(dm_be), 0);
        chk("arst im_valid", 32'(im_valid), 0);
        chk("arst im_O", im_O, 0);
        chk("arst im_D", im_D, 0);
        chk("arst timeout_err", 32'(timeout_err), 0);
        chk("arst stall", 32'(stall), 0);
        q.delete();
        m_tmo  = 1'b0;
        m_last = '{default: '0};
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        do_op(1, 0, 2'b01, 0, 32'h602, 32'h0, 2, 32'h8001_0000, 1);
        chk("post-rst lh", im_D, 32'hFFFF8001);
        @(negedge clk);
        chk("queue drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
